cache_nway: RTL
===============

CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 Parameter WAYS, default 2: associativity, power of two, range 1..8.
REQ-002 Parameter SETS, default 8: number of sets, power of two.
REQ-003 Parameter WORDS, default 8: 32-bit words per line, power of two, range 2..16.
REQ-004 Parameter WBUF_DEPTH, default 4: write-buffer entries, power of two, minimum 2.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Ports address and writeData, input, 32 bits each: CPU word address (bits [1:0] ignored) and store data.
REQ-008 Ports readMem and writeMem, input, 1 bit each: CPU load and store requests; held until stopCPU is low.
REQ-009 Port data, output, 32 bits: load data, valid when readMem=1 and stopCPU=0.
REQ-010 Port stopCPU, output, 1 bit: stalls the CPU pipeline.
REQ-011 Ports mem_req and mem_we, output, 1 bit each: memory request valid, and 1=write / 0=read.
REQ-012 Ports mem_addr and mem_wdata, output, 32 bits each: memory word address and write data.
REQ-013 Port mem_ack, input, 1 bit: a beat completes in any cycle where mem_req=1 and mem_ack=1.
REQ-014 Port mem_rdata, input, 32 bits: read data, valid in the cycle of the ack.

Function
REQ-015 Addressing: offset=address[2+:log2(WORDS)], index=next log2(SETS) bits, tag=the remaining upper bits.
REQ-016 Hit: a way in the indexed set has valid=1 and a matching tag; data returns combinationally in the same cycle, with stopCPU=0.
REQ-017 Write policy: write-through, no-write-allocate.
REQ-018 Write hit: updates the word in the hitting way in the same edge, and enqueues {address, writeData} to the write buffer.
REQ-019 Write miss: only enqueues to the write buffer; no cache state changes.
REQ-020 Write with the buffer full: stopCPU=1 and nothing is written; the write completes on the first cycle the buffer has space.
REQ-021 FSM states: IDLE, DRAIN, FILL.
REQ-022 IDLE: while the buffer is non-empty, issue head-entry writes (mem_we=1); pop the entry on ack.
REQ-023 IDLE on a read miss: go to DRAIN if the buffer is non-empty, otherwise go to FILL; stopCPU=1 from the miss cycle onward.
REQ-024 DRAIN: keep writing buffer entries until the buffer is empty, then go to FILL; this keeps memory coherent before the refill.
REQ-025 FILL: issue WORDS reads at {tag,index,beat,2'b00}, beat=0..WORDS-1; each acked word is written into the victim way.
REQ-026 Last acked FILL beat: set the victim's valid bit and tag, then return to IDLE; the held load then hits in the next cycle.
REQ-027 Read-miss latency with zero-wait memory: WORDS+1 stall cycles, plus drain beats.
REQ-028 Victim choice: the first invalid way, otherwise the replacement policy; the victim is latched at FILL entry.
REQ-029 Buffer writes during DRAIN/FILL: blocked, because stopCPU is already 1.
REQ-030 readMem and writeMem both high is illegal; the bench asserts it never occurs.
REQ-031 Write buffer: FIFO with wrap-around pointers and an occupancy counter.
REQ-032 Simultaneous enqueue and dequeue when full: allowed, and the count is unchanged.

Reset
REQ-033 On rst low: all valid bits cleared, FSM=IDLE, buffer empty, replacement state zeroed.
REQ-034 Outputs during reset: stopCPU=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-035 Reset asserted mid-FILL: the partial line is discarded (never marked valid).

Configuration
REQ-036 Macro CACHE_NWAY_LRU_EN defined: true LRU per set, using age counters of log2(WAYS) bits; ages are updated on every hit and every fill.
REQ-037 Macro CACHE_NWAY_LRU_EN undefined: one round-robin pointer per set, advanced on each fill.

Structure
REQ-038 Package cache_pkg SHALL hold the FSM state enum, the line-metadata typedef {valid, tag}, and the address-field width functions.
REQ-039 The write buffer SHALL be the sub-module cache_wbuf, parametrised by WBUF_DEPTH.

Verification
REQ-040 Cold read of 0x100, zero-wait memory: stopCPU high for 9 cycles, 8 read beats at 0x100..0x11C, then data=mem[0x100].
REQ-041 Store 0xDEADBEEF to 0x104 (hit) followed by a load of 0x104: the load returns 0xDEADBEEF with no stall; memory write observed at 0x104.
REQ-042 Five back-to-back stores with WBUF_DEPTH=4 and mem_ack held low: stopCPU=1 on the 5th store until the first ack.
REQ-043 Read miss with 3 entries buffered: 3 write beats occur before the first fill read beat.
REQ-044 WAYS=2 set-conflict test, reading 0x000, 0x100, 0x000, 0x200 (all set 0): the LRU build evicts 0x100; the round-robin build evicts 0x000.
REQ-045 rst pulsed low at beat 3 of a FILL: after release, a load of the same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and address-field helpers for the cache_nway slice.
//   cacheState_t : controller states (IDLE, DRAIN, FILL)
//   lineMeta_t   : per-line metadata {valid, tag}; the tag field is sized for
//                  the widest possible tag, and narrower configurations keep
//                  the unused upper bits at zero.
//   offW/idxW/tagW/wayW : field widths derived from the cache geometry.
// Configuration macro used by the slice: CACHE_NWAY_LRU_EN (see cache_nway.sv).
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } cacheState_t;

  // Word addresses are 30 bits (byte bits [1:0] dropped), so no tag is wider.
  localparam int TAG_MAX = 30;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
  } lineMeta_t;

  function automatic int offW(input int words);
    return $clog2(words);
  endfunction

  // SETS must be at least 2 so the index field is never zero-width.
  function automatic int idxW(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagW(input int words, input int sets);
    return TAG_MAX - offW(words) - idxW(sets);
  endfunction

  // Way selectors keep at least one bit so a direct-mapped build still elaborates.
  function automatic int wayW(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_wbuf.sv
// cache_wbuf: write-buffer FIFO with wrap-around pointers and occupancy count.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   push, pushData  : enqueue request and entry
//   pop             : dequeue the head entry (ignored when empty)
//   headData        : current head entry (valid when !empty)
//   empty, full     : status flags
//   count           : number of occupied entries
// A push while full is accepted when a pop happens in the same cycle.
module cache_wbuf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       headData,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // DEPTH is a power of two, so plain pointer overflow is the wrap-around.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr] <= pushData;
  end

  assign headData = store[rdPtr];

endmodule

// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative, write-through / no-write-allocate cache.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   address, writeData     : CPU word address (bits [1:0] ignored), store data
//   readMem, writeMem      : CPU load / store requests, held while stopCPU=1
//   data, stopCPU          : load data (same-cycle on hit), pipeline stall
//   mem_req, mem_we        : memory beat request, 1=write 0=read
//   mem_addr, mem_wdata    : memory address / write data
//   mem_ack, mem_rdata     : beat acknowledge, read data in the ack cycle
// Macro CACHE_NWAY_LRU_EN: defined -> true LRU (per-set age counters);
//                          undefined -> per-set round-robin pointer.
module cache_nway
  import cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int WORDS      = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        readMem,
  input  logic        writeMem,
  output logic [31:0] data,
  output logic        stopCPU,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W  = offW(WORDS);
  localparam int IDX_W  = idxW(SETS);
  localparam int TAG_W  = tagW(WORDS, SETS);
  localparam int WAY_W  = wayW(WAYS);
  localparam int LINE_W = TAG_W + IDX_W;
  localparam int CNT_W  = $clog2(WBUF_DEPTH) + 1;

  // Address decode
  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [1:0]       unusedByteBits;

  assign offset         = address[2 +: OFF_W];
  assign index          = address[2+OFF_W +: IDX_W];
  assign tag            = address[31 -: TAG_W];
  assign unusedByteBits = address[1:0];

  // State
  cacheState_t      state;
  lineMeta_t        meta    [WAYS][SETS];
  logic [31:0]      dataArr [WAYS][SETS][WORDS];
  logic [OFF_W-1:0] beat;
  logic [WAY_W-1:0] victimReg;
  logic [LINE_W-1:0] fillLine;
  logic [IDX_W-1:0] fillIdx;
  logic [TAG_W-1:0] fillTag;

  assign fillIdx = fillLine[IDX_W-1:0];
  assign fillTag = fillLine[LINE_W-1 -: TAG_W];

  // Write buffer
  logic [63:0]      wbHead;
  logic             wbEmpty;
  logic             wbFull;
  logic [CNT_W-1:0] wbCount;
  logic             push;
  logic             pop;

  // Lookup
  logic [WAYS-1:0]  hitVec;
  logic             hit;
  logic [WAY_W-1:0] hitWay;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] replVictim;
  logic             foundInvalid;
  logic             fillLast;
  logic             drainDone;

  for (genvar gi = 0; gi < WAYS; gi++) begin : gHit
    assign hitVec[gi] = meta[gi][index].valid &&
                        (meta[gi][index].tag[TAG_W-1:0] == tag);
  end

  assign hit = |hitVec;

  always_comb begin
    hitWay = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hitVec[w]) hitWay = WAY_W'(w);
    end
  end

  assign data = dataArr[hitWay][index][offset];

  // Victim: lowest-numbered invalid way, else whatever the policy nominates.
  always_comb begin
    victim       = replVictim;
    foundInvalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!foundInvalid && !meta[w][index].valid) begin
        victim       = WAY_W'(w);
        foundInvalid = 1'b1;
      end
    end
  end

  // Buffer handshakes. A store is taken only in IDLE; when the buffer is full
  // it still goes in if the head is being retired in the same cycle.
  assign pop       = (state != FILL) && !wbEmpty && mem_ack;
  assign push      = (state == IDLE) && writeMem && !readMem && (!wbFull || pop);
  assign fillLast  = (state == FILL) && mem_ack && (beat == OFF_W'(WORDS-1));
  assign drainDone = wbEmpty || ((wbCount == CNT_W'(1)) && pop);

  cache_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (64)
  ) uWbuf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData ({address[31:2], 2'b00, writeData}),
    .pop      (pop),
    .headData (wbHead),
    .empty    (wbEmpty),
    .full     (wbFull),
    .count    (wbCount)
  );

`ifdef CACHE_NWAY_LRU_EN
  // Age 0 = most recent. On a touch, every way no older than the touched one
  // ages by one; this also converges from the all-zero reset state.
  logic [WAY_W-1:0] age [SETS][WAYS];
  logic             accHit;
  logic             touch;
  logic [IDX_W-1:0] touchSet;
  logic [WAY_W-1:0] touchWay;

  assign accHit = (state == IDLE) && hit && ((readMem && !writeMem) || push);

  always_comb begin
    touch    = accHit;
    touchSet = index;
    touchWay = hitWay;
    if (fillLast) begin
      touch    = 1'b1;
      touchSet = fillIdx;
      touchWay = victimReg;
    end
  end

  always_comb begin
    replVictim = '0;
    for (int w = 1; w < WAYS; w++) begin
      if (age[index][w] > age[index][replVictim]) replVictim = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= '0;
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touchWay)
          age[touchSet][w] <= '0;
        else if ((age[touchSet][w] <= age[touchSet][touchWay]) &&
                 (age[touchSet][w] != WAY_W'(WAYS-1)))
          age[touchSet][w] <= age[touchSet][w] + 1'b1;
      end
    end
  end
`else
  logic [WAY_W-1:0] rrPtr [SETS];

  assign replVictim = rrPtr[index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) rrPtr[s] <= '0;
    end else if (fillLast) begin
      rrPtr[fillIdx] <= (rrPtr[fillIdx] == WAY_W'(WAYS-1)) ? '0 : rrPtr[fillIdx] + 1'b1;
    end
  end
`endif

  // Controller and line metadata
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      victimReg <= '0;
      fillLine  <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          meta[w][s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (readMem && !hit) begin
            fillLine <= address[31 -: LINE_W];
            beat     <= '0;
            if (!wbEmpty) begin
              state <= DRAIN;
            end else begin
              state     <= FILL;
              victimReg <= victim;
            end
          end
        end
        DRAIN: begin
          // The load is held, so index still selects the set being refilled.
          if (drainDone) begin
            state     <= FILL;
            victimReg <= victim;
          end
        end
        FILL: begin
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (fillLast) begin
              meta[victimReg][fillIdx] <= '{valid: 1'b1, tag: TAG_MAX'(fillTag)};
              state                    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data: refill beats and store hits never coincide (FILL vs IDLE).
  always_ff @(posedge clk) begin
    if ((state == FILL) && mem_ack)
      dataArr[victimReg][fillIdx][beat] <= mem_rdata;
    else if (push && hit)
      dataArr[hitWay][index][offset] <= writeData;
  end

  // Memory side is decoded from registers only, so it is stable all cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE, DRAIN: begin
        if (!wbEmpty) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wbHead[63:32];
          mem_wdata = wbHead[31:0];
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {fillLine, beat, 2'b00};
      end
      default: ;
    endcase
  end

  always_comb begin
    stopCPU = 1'b0;
    if (rst) begin
      if (state == IDLE)
        stopCPU = (readMem && !hit) || (writeMem && wbFull && !pop);
      else
        stopCPU = readMem || writeMem;
    end
  end

endmodule
